// File: rtl/formula_pkg.sv
// Shared widths and result type for the formula pipeline and its output buffer.
package formula_pkg;

  localparam int def_width = 8;

  function automatic int result_width(input int w);
    return 2 * w + 6;
  endfunction

  localparam int def_width_out = result_width(def_width);

  typedef logic signed [def_width_out-1:0] result_t;

endpackage

// File: rtl/formula_out_fifo_mem.sv
// Result storage for formula_out_buf: one synchronous write port, one asynchronous read port.
module formula_out_fifo_mem
  import formula_pkg::*;
#(
  parameter int depth     = 8,
  parameter int width_out = def_width_out,
  parameter int aw        = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [aw-1:0]        waddr,
  input  logic [width_out-1:0] wdata,
  input  logic [aw-1:0]        raddr,
  output logic [width_out-1:0] rdata
);

  logic [width_out-1:0] mem [depth];

  // NOTE: storage has no reset; valid entries are tracked by the pointers, so clearing it only costs logic.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/formula_out_buf.sv
// In-order result buffer behind the formula pipeline with credit-based upstream flow control.
module formula_out_buf
  import formula_pkg::*;
#(
  parameter int width     = def_width,
  parameter int width_out = result_width(width),
  parameter int depth     = 8,
  parameter int cnt_w     = $clog2(depth + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_vld,
  input  logic                        in_vld,
  input  logic signed [width_out-1:0] in_q,
  output logic                        ready_up,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic signed [width_out-1:0] out_q,
  output logic [cnt_w-1:0]            level,
  input  logic                        ovf_clr,
  output logic                        ovf,
  output logic                        proto_err
);

  localparam int aw = $clog2(depth);

  typedef logic [aw:0] ptr_t;

  localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);
  localparam ptr_t             ptr_one = ptr_t'(1);

  ptr_t                 wr_ptr, rd_ptr;
  logic [cnt_w-1:0]     level_q, inflight;
  logic                 ovf_q, proto_err_q;
  logic [width_out-1:0] rd_data;

  logic             full, empty, pop, push_ok, drop, proto_set;
  logic [cnt_w:0]   committed;

  // Every issued op owns a slot either in the FIFO or in the pipeline; the sum is kept one bit wider.
  assign committed = {1'b0, level_q} + {1'b0, inflight};
  assign full      = (level_q == depth_c);
  assign empty     = (level_q == '0);

  assign ready_up  = !rst && (committed < {1'b0, depth_c});
  assign out_vld   = !rst && !empty;
  assign out_q     = out_vld ? rd_data : '0;

  assign pop       = out_vld && out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push_ok   = in_vld && (!full || pop);
  assign drop      = in_vld && full && !pop;
  assign proto_set = (in_vld && inflight == '0) || (issue_vld && !ready_up);

  formula_out_fifo_mem #(
    .depth     (depth),
    .width_out (width_out),
    .aw        (aw)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !rst),
    .waddr (wr_ptr[aw-1:0]),
    .wdata (in_q),
    .raddr (rd_ptr[aw-1:0]),
    .rdata (rd_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      inflight    <= '0;
      ovf_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_one;
      if (pop)     rd_ptr <= rd_ptr + ptr_one;

      case ({push_ok, pop})
        2'b10:   level_q <= level_q + cnt_one;
        2'b01:   level_q <= level_q - cnt_one;
        default: level_q <= level_q;
      endcase

      // Issue and return in the same cycle cancel; the counter clamps at both ends.
      case ({issue_vld, in_vld})
        2'b10:   if (inflight != depth_c) inflight <= inflight + cnt_one;
        2'b01:   if (inflight != '0)      inflight <= inflight - cnt_one;
        default: inflight <= inflight;
      endcase

      ovf_q       <= drop      || (ovf_q       && !ovf_clr);
      proto_err_q <= proto_set || (proto_err_q && !ovf_clr);
    end
  end

  assign level     = level_q;
  assign ovf       = ovf_q;
  assign proto_err = proto_err_q;

endmodule
